// File: rtl/dvp_frame_source_if.sv
// dvp_frame_source_if: configuration, trigger and DVP/echo output bundle for dvp_frame_source
//   master: drives start/continuous, pattern config (fg/bg pixel, plant rows), trig_in and echo config
//   slave : the frame source; drives vsync/href/pclk_out/data, echo_out, busy and frame_done
interface dvp_frame_source_if;
  logic        start;
  logic        continuous;
  logic [15:0] fg_pixel;
  logic [15:0] bg_pixel;
  logic [7:0]  plant_top;
  logic [7:0]  plant_bottom;
  logic        trig_in;
  logic [7:0]  echo_delay;
  logic [15:0] echo_len;
  logic        vsync;
  logic        href;
  logic        pclk_out;
  logic [7:0]  data;
  logic        echo_out;
  logic        busy;
  logic        frame_done;
  modport master (
    output start, continuous, fg_pixel, bg_pixel, plant_top, plant_bottom, trig_in, echo_delay, echo_len,
    input  vsync, href, pclk_out, data, echo_out, busy, frame_done
  );
  modport slave (
    input  start, continuous, fg_pixel, bg_pixel, plant_top, plant_bottom, trig_in, echo_delay, echo_len,
    output vsync, href, pclk_out, data, echo_out, busy, frame_done
  );
endinterface

// File: rtl/dvp_frame_source.sv
// dvp_frame_source: synthetic DVP camera frame generator with plant test pattern plus ultrasonic echo responder
//   clk   : system clock, one pixel byte per cycle
//   rst_n : asynchronous active-low reset
//   bus   : dvp_frame_source_if.slave (frame/echo config and trigger in; vsync, href, pclk_out, data,
//           echo_out, busy, frame_done out, all registered)
module dvp_frame_source #(
  parameter int H_PIXELS      = 16,
  parameter int V_ROWS        = 8,
  parameter int VSYNC_CYCLES  = 4,
  parameter int VBLANK_CYCLES = 2,
  parameter int HBLANK_CYCLES = 4
) (
  input logic              clk,
  input logic              rst_n,
  dvp_frame_source_if.slave bus
);
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT} state_e;
  typedef enum logic [1:0] {E_IDLE, E_WAIT, E_HIGH} estate_e;
  localparam logic [15:0] VS_LAST  = 16'(VSYNC_CYCLES - 1);
  localparam logic [15:0] VB_LAST  = 16'(VBLANK_CYCLES - 1);
  localparam logic [15:0] LN_LAST  = 16'(2 * H_PIXELS - 1);
  localparam logic [15:0] HB_LAST  = 16'(HBLANK_CYCLES - 1);
  localparam logic [7:0]  ROW_LAST = 8'(V_ROWS - 1);
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  row_q, row_d;
  logic [15:0] fg_q, fg_d, bg_q, bg_d;
  logic [7:0]  top_q, top_d, bot_q, bot_d;
  logic        cap;
  logic        frame_end;
  logic [15:0] pix;
  logic [7:0]  pix_byte;
  estate_e     es_q, es_d;
  logic [7:0]  dly_q, dly_d;
  logic [15:0] len_q, len_d, ecnt_q, ecnt_d;
  logic        trig_q, trig_edge;
  logic        vsync_q, href_q, pclk_q, echo_q, busy_q, fend_q, done_q;
  logic [7:0]  data_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    row_d   = row_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        row_d = '0;
        if (bus.start || bus.continuous) begin
          state_d = VSYNC;
          cap     = 1'b1;
        end
      end
      VSYNC: if (cnt_q == VS_LAST) begin
        state_d = VBACK;
        cnt_d   = '0;
      end
      VBACK: if (cnt_q == VB_LAST) begin
        state_d = LINE;
        cnt_d   = '0;
        row_d   = '0;
      end
      LINE: if (cnt_q == LN_LAST) begin
        state_d = (row_q == ROW_LAST) ? VFRONT : HBLANK;
        cnt_d   = '0;
      end
      HBLANK: if (cnt_q == HB_LAST) begin
        state_d = LINE;
        cnt_d   = '0;
        row_d   = row_q + 8'd1;
      end
      VFRONT: if (cnt_q == VB_LAST) begin
        state_d = bus.continuous ? VSYNC : IDLE;
        cap     = bus.continuous;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    fg_d  = cap ? bus.fg_pixel : fg_q;
    bg_d  = cap ? bus.bg_pixel : bg_q;
    top_d = cap ? bus.plant_top : top_q;
    bot_d = cap ? bus.plant_bottom : bot_q;
  end
  // frame_done trails the last VFRONT cycle by two so it lands on the cycle where the next frame's vsync appears
  assign frame_end = (state_q == VFRONT) && (cnt_q == VB_LAST);
  assign pix       = (top_q <= row_q && row_q <= bot_q) ? fg_q : bg_q;
  assign pix_byte  = cnt_q[0] ? pix[7:0] : pix[15:8];
  assign trig_edge = bus.trig_in && !trig_q;
  always_comb begin
    es_d   = es_q;
    dly_d  = dly_q;
    len_d  = len_q;
    ecnt_d = ecnt_q + 16'd1;
    case (es_q)
      E_IDLE: begin
        ecnt_d = '0;
        if (trig_edge) begin
          dly_d = bus.echo_delay;
          len_d = bus.echo_len;
          // a zero delay skips the wait so the echo rises right after the trigger edge
          es_d  = (bus.echo_len == 16'd0) ? E_IDLE : (bus.echo_delay == 8'd0) ? E_HIGH : E_WAIT;
        end
      end
      E_WAIT: if (ecnt_q == {8'd0, dly_q - 8'd1}) begin
        es_d   = E_HIGH;
        ecnt_d = '0;
      end
      E_HIGH: if (ecnt_q == len_q - 16'd1) begin
        es_d   = E_IDLE;
        ecnt_d = '0;
      end
      default: begin
        es_d   = E_IDLE;
        ecnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
      top_q   <= '0;
      bot_q   <= '0;
      es_q    <= E_IDLE;
      dly_q   <= '0;
      len_q   <= '0;
      ecnt_q  <= '0;
      trig_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      pclk_q  <= 1'b0;
      data_q  <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      fend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      es_q    <= es_d;
      dly_q   <= dly_d;
      len_q   <= len_d;
      ecnt_q  <= ecnt_d;
      trig_q  <= bus.trig_in;
      vsync_q <= state_q == VSYNC;
      href_q  <= state_q == LINE;
      pclk_q  <= state_q == LINE && !cnt_q[0];
      data_q  <= (state_q == LINE) ? pix_byte : 8'h00;
      echo_q  <= es_q == E_HIGH;
      busy_q  <= state_q != IDLE;
      fend_q  <= frame_end;
      done_q  <= fend_q;
    end
  end
  assign bus.vsync      = vsync_q;
  assign bus.href       = href_q;
  assign bus.pclk_out   = pclk_q;
  assign bus.data       = data_q;
  assign bus.echo_out   = echo_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_dvp_frame_source.sv
// tb_dvp_frame_source: randomized self-checking bench for dvp_frame_source against an arithmetic frame/echo model
module tb_dvp_frame_source;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int VS = 4;
  localparam int VB = 2;
  localparam int HB = 4;
  localparam int FL = VS + 2 * VB + V * 2 * H + (V - 1) * HB;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [12:0] obs;
  dvp_frame_source_if bus();
  dvp_frame_source #(.H_PIXELS(H), .V_ROWS(V), .VSYNC_CYCLES(VS), .VBLANK_CYCLES(VB), .HBLANK_CYCLES(HB))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign obs = {bus.vsync, bus.href, bus.pclk_out, bus.data, bus.busy, bus.frame_done};
  // expected {vsync, href, pclk, data, busy, frame_done} k cycles after start is sampled, single frame
  function automatic logic [12:0] exp_out(int k, logic [15:0] fg, logic [15:0] bg, logic [7:0] top, logic [7:0] bot);
    int j, r, b;
    logic [15:0] p;
    logic hr;
    j  = k - (VS + VB + 1);
    r  = (j >= 0) ? j / (2 * H + HB) : 0;
    b  = (j >= 0) ? j % (2 * H + HB) : 0;
    hr = (j >= 0) && (r < V) && (b < 2 * H);
    p  = (int'(top) <= r && r <= int'(bot)) ? fg : bg;
    return {k >= 1 && k <= VS, hr, hr && (b % 2 == 0), hr ? ((b % 2 == 0) ? p[15:8] : p[7:0]) : 8'h00,
            k >= 1 && k <= FL, k == FL + 1};
  endfunction
  task automatic idle_inputs();
    bus.start = 1'b0; bus.continuous = 1'b0; bus.fg_pixel = '0; bus.bg_pixel = '0;
    bus.plant_top = '0; bus.plant_bottom = '0; bus.trig_in = 1'b0; bus.echo_delay = '0; bus.echo_len = '0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (obs !== 13'd0) begin bad++; $display("FAIL reset_frame got=%h exp=0", obs); end
    total++; if (bus.echo_out !== 1'b0) begin bad++; $display("FAIL reset_echo got=%b exp=0", bus.echo_out); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_single_frame();
    logic [15:0] fg = 16'h07E0, bg = 16'hF800;
    logic [7:0] top = 8'd2, bot = 8'd5;
    logic [12:0] e;
    bus.fg_pixel = fg; bus.bg_pixel = bg; bus.plant_top = top; bus.plant_bottom = bot;
    @(negedge clk) bus.start = 1'b1;
    for (int k = 0; k <= FL + 3; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      e = exp_out(k, fg, bg, top, bot);
      total++; if (obs !== e) begin bad++; $display("FAIL single_frame k=%0d got=%h exp=%h", k, obs, e); end
    end
  endtask
  task automatic test_empty_plant();
    logic [15:0] fg = 16'($urandom), bg = 16'hF800;
    logic [7:0] top = 8'd6, bot = 8'd3;
    logic [12:0] e;
    bus.fg_pixel = fg; bus.bg_pixel = bg; bus.plant_top = top; bus.plant_bottom = bot;
    @(negedge clk) bus.start = 1'b1;
    for (int k = 0; k <= FL + 3; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (k == 100) begin bus.fg_pixel = ~fg; bus.bg_pixel = 16'h1234; bus.plant_top = 0; bus.plant_bottom = 8'd7; end
      e = exp_out(k, fg, bg, top, bot);
      total++; if (obs !== e) begin bad++; $display("FAIL empty_plant k=%0d got=%h exp=%h", k, obs, e); end
    end
  endtask
  task automatic test_random_frame();
    logic [15:0] fg, bg;
    logic [7:0] top, bot;
    logic [12:0] e;
    for (int n = 0; n < 2; n++) begin
      fg = 16'($urandom); bg = 16'($urandom);
      top = 8'($urandom_range(0, 9)); bot = 8'($urandom_range(0, 9));
      bus.fg_pixel = fg; bus.bg_pixel = bg; bus.plant_top = top; bus.plant_bottom = bot;
      @(negedge clk) bus.start = 1'b1;
      for (int k = 0; k <= FL + 20; k++) begin
        @(negedge clk);
        bus.start = (k == 60);
        e = exp_out(k, fg, bg, top, bot);
        total++; if (obs !== e) begin bad++; $display("FAIL random_frame n=%0d k=%0d got=%h exp=%h", n, k, obs, e); end
      end
    end
  endtask
  task automatic test_continuous();
    logic [2:0] e, o;
    bus.fg_pixel = 16'($urandom); bus.bg_pixel = 16'($urandom);
    @(negedge clk) bus.continuous = 1'b1;
    for (int k = 0; k <= 3 * FL + 100; k++) begin
      @(negedge clk);
      if (k == 2 * FL + 100) bus.continuous = 1'b0;
      bus.start = (k == FL + 100);
      o = {bus.vsync, bus.busy, bus.frame_done};
      e = {k >= 1 && k <= 3 * FL && (k - 1) % FL < VS, k >= 1 && k <= 3 * FL, k > FL && k <= 3 * FL + 1 && (k - 1) % FL == 0};
      total++; if (o !== e) begin bad++; $display("FAIL continuous k=%0d got=%b exp=%b", k, o, e); end
    end
  endtask
  task automatic test_echo();
    logic e;
    int d, l;
    bus.echo_delay = 8'd10; bus.echo_len = 16'd100;
    @(negedge clk) bus.trig_in = 1'b1;
    for (int k = 0; k <= 130; k++) begin
      @(negedge clk);
      if (k == 20 || k == 60) bus.trig_in = 1'b0;
      if (k == 49) bus.trig_in = 1'b1;
      e = k >= 11 && k <= 110;
      total++; if (bus.echo_out !== e) begin bad++; $display("FAIL echo_fixed k=%0d got=%b exp=%b", k, bus.echo_out, e); end
    end
    for (int n = 0; n < 5; n++) begin
      d = (n == 0) ? 0 : $urandom_range(0, 15);
      l = $urandom_range(1, 30);
      bus.echo_delay = 8'(d); bus.echo_len = 16'(l);
      @(negedge clk) bus.trig_in = 1'b1;
      for (int k = 0; k <= d + l + 4; k++) begin
        @(negedge clk);
        if (k == 0) bus.trig_in = 1'b0;
        e = k >= d + 1 && k <= d + l;
        total++; if (bus.echo_out !== e) begin bad++; $display("FAIL echo_rand d=%0d l=%0d k=%0d got=%b exp=%b", d, l, k, bus.echo_out, e); end
      end
    end
    bus.echo_delay = 8'd5; bus.echo_len = 16'd0;
    @(negedge clk) bus.trig_in = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (k == 0) bus.trig_in = 1'b0;
      total++; if (bus.echo_out !== 1'b0) begin bad++; $display("FAIL echo_len0 k=%0d got=%b exp=0", k, bus.echo_out); end
    end
  endtask
  task automatic test_reset_mid();
    logic [15:0] fg, bg;
    logic [7:0] top, bot;
    logic [12:0] e;
    bus.fg_pixel = 16'h1234; bus.bg_pixel = 16'h5678; bus.plant_top = 8'd0; bus.plant_bottom = 8'd7;
    bus.echo_delay = 8'd3; bus.echo_len = 16'd2000;
    @(negedge clk) begin bus.start = 1'b1; bus.trig_in = 1'b1; end
    for (int k = 0; k <= VS + VB + 1 + 3 * (2 * H + HB) + 10; k++) begin
      @(negedge clk);
      if (k == 0) begin bus.start = 1'b0; bus.trig_in = 1'b0; end
    end
    total++; if ({bus.href, bus.echo_out} !== 2'b11) begin bad++; $display("FAIL pre_reset href_echo got=%b exp=11", {bus.href, bus.echo_out}); end
    rst_n = 1'b0;
    #1;
    total++; if ({obs, bus.echo_out} !== 14'd0) begin bad++; $display("FAIL reset_mid got=%h exp=0", {obs, bus.echo_out}); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({obs, bus.echo_out} !== 14'd0) begin bad++; $display("FAIL post_release got=%h exp=0", {obs, bus.echo_out}); end
    fg = 16'($urandom); bg = 16'($urandom); top = 8'($urandom_range(0, 4)); bot = 8'($urandom_range(3, 7));
    bus.fg_pixel = fg; bus.bg_pixel = bg; bus.plant_top = top; bus.plant_bottom = bot;
    @(negedge clk) bus.start = 1'b1;
    for (int k = 0; k <= FL + 3; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      e = exp_out(k, fg, bg, top, bot);
      total++; if (obs !== e) begin bad++; $display("FAIL frame_after_reset k=%0d got=%h exp=%h", k, obs, e); end
    end
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_single_frame();
    test_empty_plant();
    test_random_frame();
    test_continuous();
    test_echo();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dvp_frame_source.md
# dvp_frame_source

Synthetic camera and ultrasonic front-end for the precision-farming ASIC. It generates DVP-style frames (vsync, href, pclk, 8-bit RGB565 byte stream) with a programmable plant-shaped test pattern. It also answers an ultrasonic trigger with a programmable echo pulse. It drives the camera/ML subsystem's inputs for on-chip self-test and for bench bring-up without a real sensor.

## Interface
- H_PIXELS, 16: pixels per line; each line is 2*H_PIXELS bytes; range 1..255.
- V_ROWS, 8: lines per frame; range 1..255.
- VSYNC_CYCLES, 4: vsync high width in clk cycles; minimum 1.
- VBLANK_CYCLES, 2: idle cycles after vsync falls and after the last line; minimum 1.
- HBLANK_CYCLES, 4: href-low cycles between lines; minimum 1.

- clk  in  1  system clock; one pixel byte per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-frame request; sampled in IDLE only.
- continuous  in  1  when 1 at end of frame, the next frame starts immediately.
- fg_pixel  in  16  RGB565 plant pixel.
- bg_pixel  in  16  RGB565 background pixel.
- plant_top  in  8  first row (0-based) using fg_pixel.
- plant_bottom  in  8  last row (inclusive) using fg_pixel.
- trig_in  in  1  ultrasonic trigger from the measurement side.
- echo_delay  in  8  cycles from trigger edge to echo rise.
- echo_len  in  16  echo high width in cycles.
- vsync  out  1  frame sync.
- href  out  1  line valid.
- pclk_out  out  1  high on the first byte of each pixel and low on the second; 0 when href=0.
- data  out  8  pixel byte; 8'h00 when href=0.
- echo_out  out  1  echo pulse.
- busy  out  1  frame FSM not in IDLE.
- frame_done  out  1  one-cycle pulse at frame end.

## Operation
- Reset: all outputs 0. FSM goes to IDLE, echo FSM to E_IDLE, and all counters to 0.
- Frame FSM states:
  - IDLE: if start=1 or continuous=1, capture fg_pixel, bg_pixel, plant_top and plant_bottom into shadow registers, then go to VSYNC.
  - VSYNC: vsync=1 for VSYNC_CYCLES cycles, then VBACK.
  - VBACK: VBLANK_CYCLES cycles, then LINE with row=0.
  - LINE: href=1 for 2*H_PIXELS cycles. After the last byte, go to VFRONT if row=V_ROWS-1, otherwise HBLANK.
  - HBLANK: HBLANK_CYCLES cycles, then LINE with row+1.
  - VFRONT: VBLANK_CYCLES cycles, then frame end.
- Frame end: frame_done=1 for one cycle. Next state is VSYNC if continuous=1, with a fresh config capture; otherwise IDLE.
- Pixel select: use the shadow fg pixel when shadow_top ≤ row ≤ shadow_bottom (unsigned). Use the shadow bg pixel otherwise. If top > bottom, every row is background.
- Byte order: even byte index carries pixel[15:8] with pclk_out=1; odd byte index carries pixel[7:0] with pclk_out=0.
- start while busy=1 is ignored. Config changes mid-frame have no effect until the next capture.
- Echo FSM:
  - E_IDLE: a trig_in rising edge (trig_in=1, registered previous value 0) captures echo_delay and echo_len. Go to E_WAIT, or stay in E_IDLE if echo_len=0.
  - E_WAIT: count the captured delay, then E_HIGH.
  - E_HIGH: echo_out=1 for echo_len cycles, then E_IDLE.
  - Trigger edges outside E_IDLE are ignored.
- The echo FSM and the frame FSM are independent and may run concurrently.

## Timing
- start=1 sampled at edge T: vsync=1 in cycles T+1..T+VSYNC_CYCLES.
- First href cycle is T+VSYNC_CYCLES+VBLANK_CYCLES+1.
- Frame length in cycles: VSYNC_CYCLES + 2*VBLANK_CYCLES + V_ROWS*2*H_PIXELS + (V_ROWS-1)*HBLANK_CYCLES. With defaults this is 292.
- frame_done is high in the cycle after the last VFRONT cycle: cycle T+293 with defaults.
- In continuous mode, vsync rises in the same cycle as frame_done, so there is no gap between frames.
- Echo: edge detected at cycle T gives echo_out=1 from T+1+echo_delay through T+echo_delay+echo_len inclusive. echo_delay=0 means the rise is at T+1.
- All outputs are registered. Reset assertion mid-frame or mid-echo forces all outputs to 0 asynchronously. After release, the block resumes from IDLE/E_IDLE.

## Test plan
- Single frame, defaults, fg=16'h07E0, bg=16'hF800, top=2, bottom=5, start pulsed once:
  - exactly 8 href pulses of 32 cycles, separated by 4-cycle gaps;
  - rows 2–5 carry bytes 07,E0 repeated; other rows carry F8,00;
  - pclk_out alternates 1,0 within href;
  - frame_done is a single pulse 293 cycles after start is sampled;
  - busy=0 afterwards.
- top=6, bottom=3: every row carries F8,00. Changing fg_pixel mid-frame does not alter the current frame.
- continuous=1 for 3 frames, then 0:
  - three frame_done pulses 292 cycles apart, with vsync rising on each frame_done cycle;
  - returns to IDLE after the third frame;
  - a start pulse during busy produces no extra frame.
- Echo: echo_delay=10, echo_len=100, trig_in rises at T:
  - echo_out is high in T+11..T+110 inclusive;
  - a second trig edge at T+50 is ignored;
  - echo_len=0 produces no pulse.
- Reset asserted mid-LINE (row 3) and mid-echo: all outputs are 0 immediately. After release and a start pulse, a complete correct frame follows starting from row 0.
